telem_target_scheduler: RTL and testbench

//   Controller for the 16-slot telemetry target register bank (per slot: X/Y/Z/T, 8 bits each).

---
 rtl/telem_pkg.sv | 20 ++
 rtl/telem_rr_pick.sv | 27 ++
 rtl/telem_target_scheduler.sv | 159 +++++++++++++++
 tb/tb_telem_target_scheduler.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/telem_pkg.sv
// Shared definitions for the telemetry target scheduler: default sizes,
// bank operation encodings and the controller state enumeration.
package telem_pkg;

    localparam int NSLOT_DEF = 16;
    localparam int SW_DEF    = 4;
    localparam int TW_DEF    = 8;

    localparam logic [1:0] OP_HOLD  = 2'b00;
    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_CLEAR = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_OFFER = 2'd2,
        ST_CLEAR = 2'd3
    } state_e;

endpackage

// File: rtl/telem_rr_pick.sv
// Combinational first-set finder: returns the first set mask bit at or after
// ptr_i, wrapping around.  With ptr_i tied to zero it is a plain priority pick.
module telem_rr_pick
    import telem_pkg::*;
#(
    parameter int NSLOT = NSLOT_DEF,
    parameter int SW    = SW_DEF
) (
    input  logic [NSLOT-1:0] mask_i,
    input  logic [SW-1:0]    ptr_i,
    output logic [SW-1:0]    idx_o,
    output logic             found_o
);

    // Scan from the farthest candidate back to ptr_i so the nearest set bit wins.
    always_comb begin
        idx_o   = '0;
        found_o = 1'b0;
        for (int i = NSLOT - 1; i >= 0; i--) begin
            if (mask_i[ptr_i + SW'(i)]) begin
                idx_o   = ptr_i + SW'(i);
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/telem_target_scheduler.sv
// Telemetry target scheduler: accepts slot loads, ages each slot's time-to-go,
// retires expired slots and offers occupied slots round-robin to fire control.
module telem_target_scheduler
    import telem_pkg::*;
#(
    parameter int NSLOT = NSLOT_DEF,
    parameter int SW    = SW_DEF,
    parameter int TW    = TW_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             ld_valid,
    output logic             ld_ready,
    input  logic [SW-1:0]    ld_slot,
    input  logic [TW-1:0]    ld_time,
    input  logic             tick,
    output logic             disp_valid,
    input  logic             disp_ready,
    output logic [SW-1:0]    disp_slot,
    output logic [NSLOT-1:0] reg_sel,
    output logic [1:0]       reg_op,
    output logic [NSLOT-1:0] occupied,
    output logic             expired
);

    state_e            state_q;
    logic [SW-1:0]     slot_q;
    logic [TW-1:0]     time_q;
    logic [SW-1:0]     rrPtr_q;
    logic [NSLOT-1:0]  regSel_q;
    logic [1:0]        regOp_q;
    logic              dispValid_q;
    logic              expired_q;

    logic [NSLOT-1:0]  occ_q;
    logic [NSLOT-1:0]  pend_q;
    logic [TW-1:0]     ttg_q [NSLOT];

    logic [SW-1:0]     rrIdx;
    logic              rrFound;
    logic [SW-1:0]     pendIdx;
    logic              pendFound;
    logic              ldFire;

    telem_rr_pick #(.NSLOT(NSLOT), .SW(SW)) u_rr_pick (
        .mask_i  (occ_q),
        .ptr_i   (rrPtr_q),
        .idx_o   (rrIdx),
        .found_o (rrFound)
    );

    telem_rr_pick #(.NSLOT(NSLOT), .SW(SW)) u_exp_pick (
        .mask_i  (pend_q),
        .ptr_i   ('0),
        .idx_o   (pendIdx),
        .found_o (pendFound)
    );

    // ld_ready is gated by reset so every output reads 0 while reset is held.
    assign ld_ready   = rst && (state_q == ST_IDLE) && enable && !pendFound;
    assign ldFire     = ld_valid && ld_ready;

    assign disp_valid = dispValid_q;
    assign disp_slot  = dispValid_q ? slot_q : '0;
    assign reg_sel    = regSel_q;
    assign reg_op     = regOp_q;
    assign occupied   = occ_q;
    assign expired    = expired_q;

    // Controller FSM: arbitrates expiry/load/offer and registers the bank command.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            slot_q      <= '0;
            time_q      <= '0;
            rrPtr_q     <= '0;
            regSel_q    <= '0;
            regOp_q     <= OP_HOLD;
            dispValid_q <= 1'b0;
            expired_q   <= 1'b0;
        end else begin
            regSel_q  <= '0;
            regOp_q   <= OP_HOLD;
            expired_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (pendFound) begin
                        slot_q    <= pendIdx;
                        regSel_q  <= NSLOT'(1) << pendIdx;
                        regOp_q   <= OP_CLEAR;
                        expired_q <= 1'b1;
                        state_q   <= ST_CLEAR;
                    end else if (ldFire) begin
                        slot_q   <= ld_slot;
                        time_q   <= ld_time;
                        regSel_q <= NSLOT'(1) << ld_slot;
                        regOp_q  <= OP_LOAD;
                        state_q  <= ST_LOAD;
                    end else if (enable && rrFound) begin
                        slot_q      <= rrIdx;
                        dispValid_q <= 1'b1;
                        state_q     <= ST_OFFER;
                    end
                end
                ST_LOAD: begin
                    state_q <= ST_IDLE;
                end
                ST_OFFER: begin
                    if (disp_ready) begin
                        dispValid_q <= 1'b0;
                        rrPtr_q     <= slot_q + SW'(1);
                        regSel_q    <= NSLOT'(1) << slot_q;
                        regOp_q     <= OP_CLEAR;
                        state_q     <= ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Per-slot occupancy, time-to-go and expiry tracking; load and clear override ageing.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            occ_q  <= '0;
            pend_q <= '0;
            for (int i = 0; i < NSLOT; i++) begin
                ttg_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NSLOT; i++) begin
                if (tick && occ_q[i] && (ttg_q[i] != '0) &&
                    !((state_q == ST_OFFER) && (slot_q == SW'(i)))) begin
                    ttg_q[i] <= ttg_q[i] - TW'(1);
                    if (ttg_q[i] == TW'(1)) begin
                        pend_q[i] <= 1'b1;
                    end
                end
                if ((state_q == ST_LOAD) && (slot_q == SW'(i))) begin
                    occ_q[i]  <= 1'b1;
                    ttg_q[i]  <= time_q;
                    pend_q[i] <= 1'b0;
                end
                if ((state_q == ST_CLEAR) && (slot_q == SW'(i))) begin
                    occ_q[i]  <= 1'b0;
                    ttg_q[i]  <= '0;
                    pend_q[i] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_telem_target_scheduler.sv
// Directed self-checking bench for the telemetry target scheduler.
module tb_telem_target_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        ld_valid;
    logic        ld_ready;
    logic [3:0]  ld_slot;
    logic [7:0]  ld_time;
    logic        tick;
    logic        disp_valid;
    logic        disp_ready;
    logic [3:0]  disp_slot;
    logic [15:0] reg_sel;
    logic [1:0]  reg_op;
    logic [15:0] occupied;
    logic        expired;

    int checks = 0;
    int errors = 0;

    telem_target_scheduler dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .ld_valid   (ld_valid),
        .ld_ready   (ld_ready),
        .ld_slot    (ld_slot),
        .ld_time    (ld_time),
        .tick       (tick),
        .disp_valid (disp_valid),
        .disp_ready (disp_ready),
        .disp_slot  (disp_slot),
        .reg_sel    (reg_sel),
        .reg_op     (reg_op),
        .occupied   (occupied),
        .expired    (expired)
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    // Safety net so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic en, input logic ldv, input logic [3:0] slot,
                                 input logic [7:0] tm, input logic tk, input logic dr);
        enable     = en;
        ld_valid   = ldv;
        ld_slot    = slot;
        ld_time    = tm;
        tick       = tk;
        disp_ready = dr;
    endtask

    // Handshake a load, then drop enable so the LOAD cycle completes back in IDLE.
    task automatic loadSlot(input logic [3:0] slot, input logic [7:0] tm);
        enable   = 1'b1;
        ld_valid = 1'b1;
        ld_slot  = slot;
        ld_time  = tm;
        step();
        enable   = 1'b0;
        ld_valid = 1'b0;
        step();
    endtask

    // One full dispatch: IDLE -> OFFER(expSlot) -> CLEAR -> IDLE with disp_ready high.
    task automatic dispatchOne(input logic [3:0] expSlot);
        step();
        checkOutput("rr_disp_valid", 32'(disp_valid), 32'd1);
        checkOutput("rr_disp_slot", 32'(disp_slot), 32'(expSlot));
        step();
        checkOutput("rr_clear_op", 32'(reg_op), 32'd2);
        checkOutput("rr_clear_sel", 32'(reg_sel), 32'(16'd1 << expSlot));
        checkOutput("rr_clear_noexp", 32'(expired), 32'd0);
        step();
    endtask

    initial begin
        rst = 1'b0;
        applyStimulus(1'b1, 1'b0, 4'd0, 8'd0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_ld_ready", 32'(ld_ready), 32'd0);
        checkOutput("rst_reg_op", 32'(reg_op), 32'd0);
        checkOutput("rst_occupied", 32'(occupied), 32'd0);
        checkOutput("rst_disp_valid", 32'(disp_valid), 32'd0);
        enable = 1'b0;
        #2 rst = 1'b1;
        step();

        // Timed load of slot 5 expiring after three ticks.
        applyStimulus(1'b1, 1'b1, 4'd5, 8'd3, 1'b0, 1'b0);
        #1;
        checkOutput("t1_ld_ready", 32'(ld_ready), 32'd1);
        step();
        checkOutput("t1_load_op", 32'(reg_op), 32'd1);
        checkOutput("t1_load_sel", 32'(reg_sel), 32'h0020);
        applyStimulus(1'b0, 1'b0, 4'd0, 8'd0, 1'b0, 1'b0);
        step();
        checkOutput("t1_occ", 32'(occupied), 32'h0020);
        checkOutput("t1_hold_op", 32'(reg_op), 32'd0);
        tick = 1'b1;
        repeat (3) step();
        tick = 1'b0;
        checkOutput("t1_pre_clear_op", 32'(reg_op), 32'd0);
        step();
        checkOutput("t1_clear_op", 32'(reg_op), 32'd2);
        checkOutput("t1_clear_sel", 32'(reg_sel), 32'h0020);
        checkOutput("t1_expired", 32'(expired), 32'd1);
        step();
        checkOutput("t1_occ_after", 32'(occupied), 32'd0);
        checkOutput("t1_expired_pulse", 32'(expired), 32'd0);

        // Round-robin dispatch of persistent slots 2, 9, 14, then 2 again.
        loadSlot(4'd2, 8'd0);
        loadSlot(4'd9, 8'd0);
        loadSlot(4'd14, 8'd0);
        checkOutput("t2_occ", 32'(occupied), 32'h4204);
        enable     = 1'b1;
        disp_ready = 1'b1;
        dispatchOne(4'd2);
        dispatchOne(4'd9);
        dispatchOne(4'd14);
        checkOutput("t2_occ_empty", 32'(occupied), 32'd0);
        loadSlot(4'd2, 8'd0);
        enable = 1'b1;
        dispatchOne(4'd2);
        applyStimulus(1'b0, 1'b0, 4'd0, 8'd0, 1'b0, 1'b0);

        // Offer of slot 4 held for ten cycles with ticks; TTG must stay frozen.
        loadSlot(4'd4, 8'd5);
        enable = 1'b1;
        step();
        checkOutput("t3_offer_valid", 32'(disp_valid), 32'd1);
        checkOutput("t3_offer_slot", 32'(disp_slot), 32'd4);
        enable = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick = (c == 3) || (c == 6);
            step();
            checkOutput("t3_hold_valid", 32'(disp_valid), 32'd1);
            checkOutput("t3_hold_slot", 32'(disp_slot), 32'd4);
        end
        tick = 1'b0;
        checkOutput("t3_ttg_frozen", 32'(dut.ttg_q[4]), 32'd5);
        disp_ready = 1'b1;
        step();
        checkOutput("t3_clear_sel", 32'(reg_sel), 32'h0010);
        checkOutput("t3_clear_noexp", 32'(expired), 32'd0);
        checkOutput("t3_valid_drop", 32'(disp_valid), 32'd0);
        disp_ready = 1'b0;
        step();

        // Pending expiry blocks a waiting load until the clear is done.
        loadSlot(4'd1, 8'd1);
        tick = 1'b1;
        step();
        tick = 1'b0;
        applyStimulus(1'b1, 1'b1, 4'd6, 8'd0, 1'b0, 1'b0);
        #1;
        checkOutput("t4_ready_blocked", 32'(ld_ready), 32'd0);
        step();
        checkOutput("t4_clear_sel", 32'(reg_sel), 32'h0002);
        checkOutput("t4_expired", 32'(expired), 32'd1);
        checkOutput("t4_ready_in_clear", 32'(ld_ready), 32'd0);
        step();
        checkOutput("t4_ready_after", 32'(ld_ready), 32'd1);
        step();
        checkOutput("t4_load_op", 32'(reg_op), 32'd1);
        checkOutput("t4_load_sel", 32'(reg_sel), 32'h0040);
        applyStimulus(1'b0, 1'b0, 4'd0, 8'd0, 1'b0, 1'b0);
        step();
        checkOutput("t4_occ", 32'(occupied), 32'h0040);

        // Tick coinciding with the LOAD cycle of slot 7: load value wins.
        applyStimulus(1'b1, 1'b1, 4'd7, 8'd1, 1'b0, 1'b0);
        step();
        applyStimulus(1'b0, 1'b0, 4'd0, 8'd0, 1'b1, 1'b0);
        step();
        tick = 1'b0;
        checkOutput("t5_occ", 32'(occupied), 32'h00C0);
        checkOutput("t5_ttg_loaded", 32'(dut.ttg_q[7]), 32'd1);
        step();
        checkOutput("t5_no_expiry_op", 32'(reg_op), 32'd0);
        checkOutput("t5_no_expiry", 32'(expired), 32'd0);
        tick = 1'b1;
        step();
        tick = 1'b0;
        step();
        checkOutput("t5_clear_sel", 32'(reg_sel), 32'h0080);
        checkOutput("t5_expired", 32'(expired), 32'd1);
        step();
        checkOutput("t5_occ_after", 32'(occupied), 32'h0040);

        // Asynchronous reset in the middle of an offer.
        enable = 1'b1;
        step();
        checkOutput("t6_offer_slot", 32'(disp_slot), 32'd6);
        checkOutput("t6_offer_valid", 32'(disp_valid), 32'd1);
        #2 rst = 1'b0;
        #1;
        checkOutput("t6_async_valid", 32'(disp_valid), 32'd0);
        checkOutput("t6_async_slot", 32'(disp_slot), 32'd0);
        checkOutput("t6_async_occ", 32'(occupied), 32'd0);
        checkOutput("t6_async_ready", 32'(ld_ready), 32'd0);
        enable = 1'b0;
        #3 rst = 1'b1;
        step();
        checkOutput("t6_occ_post", 32'(occupied), 32'd0);
        loadSlot(4'd9, 8'd0);
        loadSlot(4'd1, 8'd0);
        enable = 1'b1;
        step();
        checkOutput("t6_rr_from_zero", 32'(disp_slot), 32'd1);
        disp_ready = 1'b1;
        step();
        checkOutput("t6_clear_sel", 32'(reg_sel), 32'h0002);
        applyStimulus(1'b0, 1'b0, 4'd0, 8'd0, 1'b0, 1'b0);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
